// File: rtl/uart_tx_packet.sv
// Serialises a 16-bit response word as two 8N1 UART frames, high byte first.
// Reports busy, done on completion, and dropped when a strobe arrives mid-packet.
module uart_tx_packet #(
    parameter int CLKS_PER_BIT   = 5208,
    parameter int INTER_BYTE_GAP = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        send_data_tx,
    input  logic [15:0] buffer_tx,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic        dropped
);

    localparam int              DivW    = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      GapLast = 4'(INTER_BYTE_GAP - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StGap} state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [2:0]      bit_q, bit_d;
    logic            byte_q, byte_d;
    logic [3:0]      gap_q, gap_d;
    logic [15:0]     shift_q, shift_d;
    logic            tx_d, busy_d, done_d, dropped_d;
    logic            div_last;
    logic [7:0]      cur_byte;

    always_comb begin
        state_d   = state_q;
        div_d     = '0;
        bit_d     = bit_q;
        byte_d    = byte_q;
        gap_d     = gap_q;
        shift_d   = shift_q;
        done_d    = 1'b0;
        dropped_d = send_data_tx && (state_q != StIdle);
        div_last  = (div_q == DivLast);

        unique case (state_q)
            StIdle: begin
                if (send_data_tx) begin
                    shift_d = buffer_tx;
                    byte_d  = 1'b0;
                    bit_d   = 3'd0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (div_last) begin
                    bit_d   = 3'd0;
                    state_d = StData;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StData: begin
                if (div_last) begin
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StStop: begin
                if (div_last) begin
                    if (byte_q) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else if (INTER_BYTE_GAP > 0) begin
                        gap_d   = 4'd0;
                        state_d = StGap;
                    end else begin
                        byte_d  = 1'b1;
                        state_d = StStart;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StGap: begin
                // Gap is counted in whole bit periods so the divider stays narrow.
                if (div_last) begin
                    if (gap_q == GapLast) begin
                        byte_d  = 1'b1;
                        state_d = StStart;
                    end else begin
                        gap_d = gap_q + 4'd1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so they are derived from next-state values.
        busy_d   = (state_d != StIdle);
        cur_byte = byte_d ? shift_d[7:0] : shift_d[15:8];
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = cur_byte[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 1'b0;
            gap_q   <= 4'd0;
            shift_q <= 16'h0000;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            dropped <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            gap_q   <= gap_d;
            shift_q <= shift_d;
            tx      <= tx_d;
            busy    <= busy_d;
            done    <= done_d;
            dropped <= dropped_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_packet.sv
// Bench for uart_tx_packet: a UART receiver model decodes tx and checks words
// against a scoreboard queue; directed checks cover timing, drops, reset and gap.
module tb_uart_tx_packet;

    localparam int CPB = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic        send_0, send_1;
    logic [15:0] buf_0, buf_1;
    logic        tx_0, busy_0, done_0, dropped_0;
    logic        tx_1, busy_1, done_1, dropped_1;

    uart_tx_packet #(.CLKS_PER_BIT(CPB), .INTER_BYTE_GAP(0)) dut0 (
        .clock        (clock),
        .reset_n      (reset_n),
        .send_data_tx (send_0),
        .buffer_tx    (buf_0),
        .tx           (tx_0),
        .busy         (busy_0),
        .done         (done_0),
        .dropped      (dropped_0)
    );

    uart_tx_packet #(.CLKS_PER_BIT(CPB), .INTER_BYTE_GAP(2)) dut1 (
        .clock        (clock),
        .reset_n      (reset_n),
        .send_data_tx (send_1),
        .buffer_tx    (buf_1),
        .tx           (tx_1),
        .busy         (busy_1),
        .done         (done_1),
        .dropped      (dropped_1)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;
    int          drop_cnt = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Receiver model: samples mid-bit, assembles two bytes, pops the scoreboard.
    initial begin : monitor
        bit          active;
        int          cnt;
        int          k;
        int          nbyte;
        logic [7:0]  sh;
        logic [7:0]  hi;
        active = 1'b0;
        cnt    = 0;
        nbyte  = 0;
        sh     = 8'h00;
        hi     = 8'h00;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                active = 1'b0;
                nbyte  = 0;
            end else begin
                if (done_0 === 1'b1) done_cnt++;
                if (dropped_0 === 1'b1) drop_cnt++;
                if (!active) begin
                    if (tx_0 === 1'b0) begin
                        active = 1'b1;
                        cnt    = 0;
                    end
                end else begin
                    cnt++;
                end
                if (active && (cnt % CPB) == CPB / 2) begin
                    k = cnt / CPB;
                    if (k == 0) begin
                        check("start_bit", {31'd0, tx_0}, 32'd0);
                    end else if (k <= 8) begin
                        sh = {tx_0, sh[7:1]};
                    end else begin
                        check("stop_bit", {31'd0, tx_0}, 32'd1);
                        active = 1'b0;
                        if (nbyte == 0) begin
                            hi    = sh;
                            nbyte = 1;
                        end else begin
                            nbyte = 0;
                            if (exp_q.size() == 0) begin
                                n_checks++;
                                n_errors++;
                                $display("FAIL tx_word: got %0h, expected no packet", {hi, sh});
                            end else begin
                                check("tx_word", {16'd0, hi, sh}, {16'd0, exp_q.pop_front()});
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic send0(input logic [15:0] w, input bit accept);
        @(posedge clock);
        #1;
        send_0 = 1'b1;
        buf_0  = w;
        if (accept) exp_q.push_back(w);
        @(posedge clock);
        #1;
        send_0 = 1'b0;
        buf_0  = 16'hDEAD;
    endtask

    task automatic wait_idle0(output int len);
        len = 0;
        @(negedge clock);
        while (busy_0 === 1'b1 && len < 1000) begin
            len++;
            @(negedge clock);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stimulus
        int          len;
        int          d0;
        int          dn;
        int          idx;
        logic [21:0] got;

        reset_n = 1'b0;
        send_0  = 1'b0;
        buf_0   = 16'h0000;
        send_1  = 1'b0;
        buf_1   = 16'h0000;

        // Held in reset: strobes must have no effect.
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            send_0 = ~send_0;
            send_1 = ~send_1;
            buf_0  = 16'h09A5;
            @(negedge clock);
            check("reset_idle", {24'd0, tx_0, busy_0, done_0, dropped_0,
                                 tx_1, busy_1, done_1, dropped_1}, 32'h88);
        end
        send_0 = 1'b0;
        send_1 = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Single packet.
        send0(16'h09A5, 1'b1);
        @(negedge clock);
        check("start_latency", {30'd0, busy_0, tx_0}, 32'b10);
        wait_idle0(len);
        check("busy_len", len + 1, 80);
        check("done_at_end", {31'd0, done_0}, 1);
        @(negedge clock);
        check("done_width", {31'd0, done_0}, 0);
        check("queue_empty_single", exp_q.size(), 0);

        // Collision: second strobe mid-packet is dropped.
        d0 = drop_cnt;
        dn = done_cnt;
        send0(16'h1FFF, 1'b1);
        repeat (29) @(posedge clock);
        #1;
        send_0 = 1'b1;
        buf_0  = 16'h0AFF;
        @(posedge clock);
        #1;
        send_0 = 1'b0;
        @(negedge clock);
        check("dropped_pulse", {30'd0, dropped_0, busy_0}, 32'b11);
        @(negedge clock);
        check("dropped_width", {31'd0, dropped_0}, 0);
        wait_idle0(len);
        check("collision_done", {31'd0, done_0}, 1);
        repeat (2) @(negedge clock);
        check("drop_count", drop_cnt - d0, 1);
        check("done_count", done_cnt - dn, 1);
        check("queue_empty_collision", exp_q.size(), 0);

        // Back-to-back: strobe in the done cycle is accepted.
        d0 = drop_cnt;
        send0(16'h07FF, 1'b1);
        wait_idle0(len);
        check("b2b_first_done", {31'd0, done_0}, 1);
        send_0 = 1'b1;
        buf_0  = 16'h0BFF;
        exp_q.push_back(16'h0BFF);
        @(posedge clock);
        #1;
        send_0 = 1'b0;
        buf_0  = 16'h1234;
        @(negedge clock);
        check("b2b_start", {29'd0, busy_0, tx_0, dropped_0}, 32'b100);
        wait_idle0(len);
        check("b2b_len", len + 1, 80);
        check("b2b_second_done", {31'd0, done_0}, 1);
        repeat (2) @(negedge clock);
        check("b2b_no_drop", drop_cnt - d0, 0);
        check("queue_empty_b2b", exp_q.size(), 0);

        // Reset during bit 3 of byte 1 (a zero bit) aborts immediately.
        send0(16'h0E52, 1'b1);
        repeat (57) @(negedge clock);
        check("pre_reset_bit", {30'd0, busy_0, tx_0}, 32'b10);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("reset_abort", {30'd0, tx_0, busy_0}, 32'b10);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        send0(16'h0CFF, 1'b1);
        wait_idle0(len);
        check("post_reset_len", len, 80);
        check("post_reset_done", {31'd0, done_0}, 1);
        @(negedge clock);
        check("queue_empty_reset", exp_q.size(), 0);

        // Inter-byte gap of two bit periods on the second instance.
        @(posedge clock);
        #1;
        send_1 = 1'b1;
        buf_1  = 16'h0DFF;
        @(posedge clock);
        #1;
        send_1 = 1'b0;
        buf_1  = 16'h0000;
        idx = 0;
        got = '0;
        @(negedge clock);
        while (busy_1 === 1'b1 && idx < 1000) begin
            if ((idx % CPB) == CPB / 2) got = {got[20:0], tx_1};
            idx++;
            @(negedge clock);
        end
        check("gap_busy_len", idx, 88);
        check("gap_waveform", {10'd0, got}, {10'd0, 22'b0101100001_11_0111111111});
        check("gap_done", {31'd0, done_1}, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
